// File: rtl/player_ctrl.sv
// Frog player controller: key stepping, riding lane objects, death/win handling
// and lives bookkeeping, all advanced once per frame_clk.
module player_ctrl #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned STEP_X    = 20,
  parameter int unsigned STEP_Y    = 40,
  parameter int unsigned X_MAX     = 600,
  parameter int unsigned Y_START   = 440,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned WATER_LO  = 80,
  parameter int unsigned WATER_HI  = 200,
  parameter int unsigned LIVES     = 3
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [10:0]            x_start,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   active,
  input  logic [NUM_LANES-1:0]   ride_hit,
  input  logic [NUM_LANES-1:0]   ride_dir,
  input  logic [6*NUM_LANES-1:0] ride_period,
  input  logic [NUM_LANES-1:0]   hazard_hit,
  input  logic                   win,
  output logic [10:0]            pos_x,
  output logic [10:0]            pos_y,
  output logic [1:0]             facing,
  output logic [2:0]             lives_left,
  output logic                   dead_pulse,
  output logic                   win_pulse,
  output logic                   game_over
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // 12-bit constants so position arithmetic never wraps before the bound test.
  localparam logic [11:0] SX    = 12'(STEP_X);
  localparam logic [11:0] SY    = 12'(STEP_Y);
  localparam logic [11:0] XMAX  = 12'(X_MAX);
  localparam logic [11:0] YST   = 12'(Y_START);
  localparam logic [11:0] YMIN  = 12'(Y_MIN);
  localparam logic [11:0] WLO   = 12'(WATER_LO);
  localparam logic [11:0] WHI   = 12'(WATER_HI);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE, S_RIDE, S_KEYWAIT, S_DEAD, S_WIN, S_RESPAWN, S_GAMEOVER
  } state_t;

  state_t             state_q, state_d;
  logic [10:0]        pos_x_q, pos_x_d;
  logic [10:0]        pos_y_q, pos_y_d;
  logic [1:0]         facing_q, facing_d;
  logic [2:0]         lives_q, lives_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [LANE_W-1:0]  lane_q, lane_d;

  logic [11:0]        px, py;
  logic               any_key, fatal;
  logic [LANE_W-1:0]  lane;
  logic [5:0]         period;
  logic [10:0]        key_x, key_y, ride_x;
  logic [1:0]         key_face;

  assign px      = {1'b0, pos_x_q};
  assign py      = {1'b0, pos_y_q};
  assign any_key = up | down | left | right;
  assign fatal   = active & ((|hazard_hit) | ((py >= WLO) & (py <= WHI) & ~(|ride_hit)));

  // Lowest-indexed overlapping lane governs the ride.
  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (ride_hit[i]) lane = LANE_W'(i);
    end
  end

  assign period = ride_period[6*lane +: 6];
  assign ride_x = ride_dir[lane] ? ((px + SX > XMAX) ? XMAX[10:0] : 11'(px + SX))
                                 : ((px < SX) ? 11'd0 : 11'(px - SX));

  // A step that would leave the playfield keeps the position but still turns the frog.
  always_comb begin
    key_x    = pos_x_q;
    key_y    = pos_y_q;
    key_face = facing_q;
    if (down) begin
      key_face = 2'b01;
      if (py + SY <= YST) key_y = 11'(py + SY);
    end else if (up) begin
      key_face = 2'b00;
      if (py >= YMIN + SY) key_y = 11'(py - SY);
    end else if (left) begin
      key_face = 2'b11;
      if (px >= SX) key_x = 11'(px - SX);
    end else if (right) begin
      key_face = 2'b10;
      if (px + SX <= XMAX) key_x = 11'(px + SX);
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no branch can infer a latch.
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    facing_d = facing_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    case (state_q)
      S_IDLE, S_RIDE: begin
        if (fatal) begin
          state_d = S_DEAD;
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end else if (win) begin
          state_d = S_WIN;
        end else if (active && any_key) begin
          state_d  = S_KEYWAIT;
          pos_x_d  = key_x;
          pos_y_d  = key_y;
          facing_d = key_face;
          cnt_d    = '0;
        end else if (active && (|ride_hit)) begin
          state_d = S_RIDE;
          lane_d  = lane;
          if (state_q != S_RIDE || lane != lane_q || period == 6'd0) begin
            cnt_d = '0;
          end else if (cnt_q == period - 6'd1) begin
            pos_x_d = ride_x;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_KEYWAIT: if (!any_key) state_d = S_IDLE;
      S_DEAD, S_WIN: begin
        // Lives were already decremented on entry to DEAD.
        if (state_q == S_DEAD && lives_q == 3'd0) begin
          state_d = S_GAMEOVER;
        end else begin
          state_d  = S_RESPAWN;
          pos_x_d  = x_start;
          pos_y_d  = YST[10:0];
          facing_d = 2'b00;
          cnt_d    = '0;
        end
      end
      S_RESPAWN:  state_d = S_IDLE;
      S_GAMEOVER: state_d = S_GAMEOVER;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pos_x_q  <= x_start;
      pos_y_q  <= YST[10:0];
      facing_q <= 2'b00;
      lives_q  <= LIVES_INIT;
      cnt_q    <= '0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      facing_q <= facing_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign facing     = facing_q;
  assign lives_left = lives_q;
  assign dead_pulse = (state_q == S_DEAD);
  assign win_pulse  = (state_q == S_WIN);
  assign game_over  = (state_q == S_GAMEOVER);

endmodule

// File: tb/tb_player_ctrl.sv
// Scenario bench for player_ctrl: expected frame results are queued with the
// stimulus and compared after the following frame_clk edge.
module tb_player_ctrl;

  logic        frame_clk, Reset;
  logic [10:0] x_start;
  logic        up, down, left, right, active, win;
  logic [3:0]  ride_hit, ride_dir, hazard_hit;
  logic [23:0] ride_period;
  logic [10:0] pos_x, pos_y;
  logic [1:0]  facing;
  logic [2:0]  lives_left;
  logic        dead_pulse, win_pulse, game_over;

  player_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .x_start(x_start),
    .up(up), .down(down), .left(left), .right(right), .active(active),
    .ride_hit(ride_hit), .ride_dir(ride_dir), .ride_period(ride_period),
    .hazard_hit(hazard_hit), .win(win),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .lives_left(lives_left),
    .dead_pulse(dead_pulse), .win_pulse(win_pulse), .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string tag;
    int    x, y, f, l, dp, wp, go;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check({e.tag, ".pos_x"},  32'(pos_x),      32'(e.x));
    check({e.tag, ".pos_y"},  32'(pos_y),      32'(e.y));
    check({e.tag, ".facing"}, 32'(facing),     32'(e.f));
    check({e.tag, ".lives"},  32'(lives_left), 32'(e.l));
    check({e.tag, ".dead"},   32'(dead_pulse), 32'(e.dp));
    check({e.tag, ".win"},    32'(win_pulse),  32'(e.wp));
    check({e.tag, ".over"},   32'(game_over),  32'(e.go));
  endtask

  // Queue the expected outputs for the current stimulus, clock once, compare.
  task automatic tick(input string tag, input int x, input int y, input int f, input int l,
                      input int dp = 0, input int wp = 0, input int go = 0);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.f = f; e.l = l; e.dp = dp; e.wp = wp; e.go = go;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    compare_all(e);
  endtask

  task automatic clear_inputs();
    up = 0; down = 0; left = 0; right = 0; active = 1; win = 0;
    ride_hit = '0; ride_dir = '0; ride_period = '0; hazard_hit = '0;
  endtask

  // Asynchronous reset applied between clock edges; outputs checked before any edge.
  task automatic do_reset(input int xs);
    exp_t e;
    Reset = 1;
    clear_inputs();
    x_start = 11'(xs);
    #2;
    e.tag = "reset"; e.x = xs; e.y = 440; e.f = 0; e.l = 3; e.dp = 0; e.wp = 0; e.go = 0;
    compare_all(e);
    Reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset = 1;
    clear_inputs();
    x_start = 11'd300;
    #3;

    // Single step per press, held key does not repeat.
    do_reset(300);
    up = 1; tick("up1", 300, 400, 0, 3);
    for (int i = 0; i < 5; i++) tick("up_hold", 300, 400, 0, 3);
    up = 0; tick("up_rel", 300, 400, 0, 3);
    up = 1; tick("up2", 300, 360, 0, 3);
    up = 0; tick("up2_rel", 300, 360, 0, 3);

    // Edge suppression: facing still turns.
    do_reset(600);
    right = 1; tick("right_edge", 600, 440, 2, 3);
    right = 0; tick("right_rel", 600, 440, 2, 3);
    down = 1;  tick("down_edge", 600, 440, 1, 3);
    down = 0;  tick("down_rel", 600, 440, 1, 3);
    left = 1;  tick("left_ok", 580, 440, 3, 3);
    left = 0;  tick("left_rel", 580, 440, 3, 3);

    // Climb into the river on a motionless ride, then ride right every 3 frames.
    do_reset(540);
    ride_hit = 4'b0001;
    for (int i = 1; i <= 7; i++) begin
      up = 1; tick("climb", 540, 440 - 40 * i, 0, 3);
      up = 0; tick("climb_rel", 540, 440 - 40 * i, 0, 3);
    end
    ride_dir = 4'b0001;
    ride_period = 24'd3;
    begin
      int exp_x[13] = '{540, 540, 540, 560, 560, 560, 580, 580, 580, 600, 600, 600, 600};
      for (int i = 0; i < 13; i++) tick("ride", exp_x[i], 160, 0, 3);
    end
    ride_hit = 4'b0000;
    tick("drown", 600, 160, 0, 2, 1);
    tick("drown_respawn", 540, 440, 0, 2);
    tick("drown_idle", 540, 440, 0, 2);

    // Hazards down to zero lives, then game over ignores input.
    hazard_hit = 4'b0010; tick("hit1", 540, 440, 0, 1, 1);
    hazard_hit = 4'b0000; tick("hit1_respawn", 540, 440, 0, 1);
    tick("hit1_idle", 540, 440, 0, 1);
    hazard_hit = 4'b0010; tick("hit2", 540, 440, 0, 0, 1);
    hazard_hit = 4'b0000; tick("gameover", 540, 440, 0, 0, 0, 0, 1);
    up = 1; hazard_hit = 4'b0010;
    tick("gameover_up", 540, 440, 0, 0, 0, 0, 1);
    tick("gameover_hold", 540, 440, 0, 0, 0, 0, 1);

    // Win beats a simultaneous key; respawn restores spawn point and keeps lives.
    do_reset(300);
    left = 1; tick("w_left", 280, 440, 3, 3);
    left = 0; tick("w_left_rel", 280, 440, 3, 3);
    win = 1; up = 1; tick("win", 280, 440, 3, 3, 0, 1);
    win = 0; up = 0; tick("win_respawn", 300, 440, 0, 3);
    tick("win_idle", 300, 440, 0, 3);

    // Two lanes overlapped: lane 1 (left, period 2) governs; key beats ride step.
    do_reset(300);
    ride_hit    = 4'b0110;
    ride_dir    = 4'b0100;
    ride_period = (24'd5 << 12) | (24'd2 << 6);
    begin
      int exp_x[6] = '{300, 300, 280, 280, 260, 260};
      for (int i = 0; i < 6; i++) tick("lane1_ride", exp_x[i], 440, 0, 3);
    end
    left = 1; tick("key_vs_ride", 240, 440, 3, 3);
    left = 0; tick("key_vs_ride_rel", 240, 440, 3, 3);

    // Inactive: keys and rides are ignored.
    active = 0; up = 1; tick("inactive", 240, 440, 3, 3);
    up = 0; tick("inactive2", 240, 440, 3, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
